issue_busy_table: RTL and testbench

// - Downstream neighbour of the register re-naming stage. Consumes re-named issue instructions
//   (6-bit physical rs1/rs2/rd) and holds each one until its operands are free of pending writes.
// - Tracks a busy bit per physical register: set on issue, cleared on writeback.
// - Releases hazard-free instructions to the functional-unit dispatch with a valid/ready handshake.

---
 rtl/issue_busy_table.sv | 117 +++++++++++
 tb/tb_issue_busy_table.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_busy_table.sv
// Single-entry issue holding register with a physical-register busy table.
// Releases an instruction to the FUs once its sources and destination carry no pending writes.
module issue_busy_table #(
    parameter int NR_PREGS    = 64,
    parameter int PREG_W      = 6,
    parameter int PAYLOAD_W   = 64,
    parameter int NR_WB_PORTS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ack_o,
    input  logic [PREG_W-1:0]             rs1_i,
    input  logic [PREG_W-1:0]             rs2_i,
    input  logic                          use_rs1_i,
    input  logic                          use_rs2_i,
    input  logic [PREG_W-1:0]             rd_i,
    input  logic                          we_rd_i,
    input  logic [PAYLOAD_W-1:0]          payload_i,
    output logic                          fu_valid_o,
    input  logic                          fu_ready_i,
    output logic [PREG_W-1:0]             fu_rs1_o,
    output logic [PREG_W-1:0]             fu_rs2_o,
    output logic [PREG_W-1:0]             fu_rd_o,
    output logic                          fu_we_rd_o,
    output logic [PAYLOAD_W-1:0]          fu_payload_o,
    input  logic [NR_WB_PORTS-1:0]        wb_valid_i,
    input  logic [NR_WB_PORTS*PREG_W-1:0] wb_rd_i,
    output logic [NR_PREGS-1:0]           busy_o,
    output logic [31:0]                   stall_cnt_o
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]                          state_q;
    logic [1:0]                          state;
    logic [PREG_W-1:0]                   h_rs1, h_rs2, h_rd;
    logic                                h_use1, h_use2, h_we;
    logic [PAYLOAD_W-1:0]                h_payload;
    logic [NR_PREGS-1:0]                 busy_q, busy_eff, busy_n, wb_clear;
    logic [NR_WB_PORTS-1:0][PREG_W-1:0]  wb_rd;
    logic [31:0]                         stall_cnt_q;
    logic                                held, hazard, fire;

    assign wb_rd = wb_rd_i;

    // Duplicate writebacks to one register collapse into a single clear.
    always_comb begin
        wb_clear = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p]) wb_clear[wb_rd[p]] = 1'b1;
        end
    end

    // Same-cycle writeback bypasses the busy bit so a stall releases immediately.
    assign busy_eff = busy_q & ~wb_clear;
    assign held     = (state_q != EMPTY);
    assign hazard   = (h_use1 & busy_eff[h_rs1]) | (h_use2 & busy_eff[h_rs2]) | (h_we & busy_eff[h_rd]);

    // Stored state only records occupancy; STALL vs READY is re-derived every cycle.
    always_comb begin
        state = EMPTY;
        if (held) state = hazard ? STALL : READY;
    end

    assign fu_valid_o  = (state == READY) & ~flush_i & ~rst_i;
    assign fire        = fu_valid_o & fu_ready_i;
    assign instr_ack_o = instr_valid_i & ~flush_i & ~rst_i & (~held | fire);

    // Physical 0 and 32 alias x0 and never become busy; a set beats a same-cycle clear.
    always_comb begin
        busy_n = busy_eff;
        if (fire && h_we && (h_rd[PREG_W-2:0] != '0)) busy_n[h_rd] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state == STALL && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i) begin
                state_q <= EMPTY;
                busy_q  <= '0;
            end else begin
                busy_q <= busy_n;
                if (instr_ack_o)  state_q <= READY;
                else if (fire)    state_q <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (instr_ack_o) begin
            h_rs1     <= rs1_i;
            h_rs2     <= rs2_i;
            h_rd      <= rd_i;
            h_use1    <= use_rs1_i;
            h_use2    <= use_rs2_i;
            h_we      <= we_rd_i;
            h_payload <= payload_i;
        end
    end

    assign fu_rs1_o     = h_rs1;
    assign fu_rs2_o     = h_rs2;
    assign fu_rd_o      = h_rd;
    assign fu_we_rd_o   = h_we;
    assign fu_payload_o = h_payload;
    assign busy_o       = busy_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_issue_busy_table.sv
// Bench for issue_busy_table: scenario tasks with inline checks plus an in-order
// scoreboard of accepted payloads popped on every FU handshake.
module tb_issue_busy_table;

    logic        clk, rst, flush, instr_valid, instr_ack;
    logic [5:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, we_rd;
    logic [63:0] payload;
    logic        fu_valid, fu_ready;
    logic [5:0]  fu_rs1, fu_rs2, fu_rd;
    logic        fu_we_rd;
    logic [63:0] fu_payload;
    logic [1:0]  wb_valid;
    logic [11:0] wb_rd;
    logic [63:0] busy;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int stall_exp = 0;
    int fire_cnt = 0;
    logic [63:0] sb[$];

    issue_busy_table dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ack_o(instr_ack),
        .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
        .rd_i(rd), .we_rd_i(we_rd), .payload_i(payload),
        .fu_valid_o(fu_valid), .fu_ready_i(fu_ready),
        .fu_rs1_o(fu_rs1), .fu_rs2_o(fu_rs2), .fu_rd_o(fu_rd),
        .fu_we_rd_o(fu_we_rd), .fu_payload_o(fu_payload),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .busy_o(busy), .stall_cnt_o(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pl(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // Scoreboard: pop before push so same-cycle release and accept stay ordered.
    always @(negedge clk) begin
        if (!rst) begin
            if (fu_valid && fu_ready) begin
                fire_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: fired payload %0h, none expected", fu_payload);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    if (fu_payload !== e) begin
                        errors++;
                        $display("FAIL sb_payload: got %0h expected %0h", fu_payload, e);
                    end
                end
            end
            if (instr_ack) sb.push_back(payload);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] a, input logic ua, input logic [5:0] b, input logic ub,
                         input logic [5:0] d, input logic w, input logic [63:0] p);
        instr_valid = 1'b1;
        rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub; rd = d; we_rd = w; payload = p;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; we_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; fu_ready = 1'b1; wb_valid = '0; wb_rd = '0;
        drive(6'd1, 1'b0, 6'd2, 1'b0, 6'd3, 1'b1, pl(99));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL rst_fu_valid: got %b expected 0", fu_valid); end
            checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", instr_ack); end
            tick();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (busy !== 64'd0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL post_rst_fu_valid: got %b expected 0", fu_valid); end
        tick();
    endtask

    task automatic test_raw();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd35, 1'b1, pl(1));
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL raw_ack1: got %b expected 1", instr_ack); end
        tick();
        drive(6'd35, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, pl(2));
        @(negedge clk);
        checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL raw_i1_valid: got %b expected 1", fu_valid); end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL raw_stall_valid: got %b expected 0", fu_valid); end
            checks++; if (busy[35] !== 1'b1) begin errors++; $display("FAIL raw_busy35: got %b expected 1", busy[35]); end
            stall_exp++;
            tick();
        end
        wb_valid = 2'b10; wb_rd = {6'd35, 6'd0};
        @(negedge clk);
        checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL raw_bypass: got %b expected 1", fu_valid); end
        checks++; if (stall_cnt !== 32'(stall_exp)) begin errors++; $display("FAIL raw_stall_cnt: got %0d expected %0d", stall_cnt, stall_exp); end
        tick();
        wb_valid = '0;
        @(negedge clk);
        checks++; if (busy[35] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr: got %b expected 0", busy[35]); end
        tick();
    endtask

    task automatic test_x0();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd32, 1'b1, pl(3));
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL x0_ack1: got %b expected 1", instr_ack); end
        tick();
        drive(6'd32, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, pl(4));
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL x0_ack2: got %b expected 1", instr_ack); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (busy[32] !== 1'b0) begin errors++; $display("FAIL x0_busy32: got %b expected 0", busy[32]); end
        checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b expected 1", fu_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd10, 1'b1, pl(5));
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL bp_ack1: got %b expected 1", instr_ack); end
        tick();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd11, 1'b1, pl(6));
        fu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", fu_valid); end
            checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL bp_ack_wait: got %b expected 0", instr_ack); end
            checks++; if (fu_payload !== pl(5) || fu_rd !== 6'd10 || fu_we_rd !== 1'b1) begin
                errors++; $display("FAIL bp_stable: got %0h/%0d/%b expected %0h/10/1", fu_payload, fu_rd, fu_we_rd, pl(5)); end
            checks++; if (busy[10] !== 1'b0) begin errors++; $display("FAIL bp_busy_early: got %b expected 0", busy[10]); end
            tick();
        end
        fu_ready = 1'b1;
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL bp_ack_fire: got %b expected 1", instr_ack); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (busy[10] !== 1'b1) begin errors++; $display("FAIL bp_busy_set: got %b expected 1", busy[10]); end
        checks++; if (fu_payload !== pl(6)) begin errors++; $display("FAIL bp_next: got %0h expected %0h", fu_payload, pl(6)); end
        tick();
        wb_valid = 2'b11; wb_rd = {6'd11, 6'd10};
        tick();
        wb_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 64'd0) begin errors++; $display("FAIL bp_wb_clr: got %0h expected 0", busy); end
        tick();
    endtask

    task automatic test_waw();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, pl(7));
        tick();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, pl(8));
        @(negedge clk);
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL waw_ack: got %b expected 1", instr_ack); end
        tick();
        idle();
        wb_valid = 2'b01; wb_rd = {6'd0, 6'd20};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b expected 0", fu_valid); end
            checks++; if (busy !== 64'h80) begin errors++; $display("FAIL waw_busy: got %0h expected 80", busy); end
            stall_exp++;
            tick();
            wb_valid = '0;
        end
        wb_valid = 2'b11; wb_rd = {6'd7, 6'd7};
        @(negedge clk);
        checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL waw_release: got %b expected 1", fu_valid); end
        tick();
        wb_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 64'h80) begin errors++; $display("FAIL waw_set_wins: got %0h expected 80", busy); end
        checks++; if (stall_cnt !== 32'(stall_exp)) begin errors++; $display("FAIL waw_stall_cnt: got %0d expected %0d", stall_cnt, stall_exp); end
        tick();
        wb_valid = 2'b01; wb_rd = {6'd0, 6'd7};
        tick();
        wb_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 64'd0) begin errors++; $display("FAIL waw_clr: got %0h expected 0", busy); end
        tick();
    endtask

    task automatic test_flush();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd35, 1'b1, pl(9));
        tick();
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd40, 1'b1, pl(10));
        tick();
        drive(6'd35, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, pl(11));
        tick();
        idle();
        @(negedge clk);
        checks++; if (busy[35] !== 1'b1 || busy[40] !== 1'b1 || fu_valid !== 1'b0) begin
            errors++; $display("FAIL fl_pre: got busy35=%b busy40=%b valid=%b expected 1 1 0", busy[35], busy[40], fu_valid); end
        stall_exp++;
        tick();
        flush = 1'b1;
        drive(6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, pl(12));
        @(negedge clk);
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", fu_valid); end
        checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL fl_ack: got %b expected 0", instr_ack); end
        stall_exp++;
        tick();
        flush = 1'b0;
        idle();
        sb.delete();
        @(negedge clk);
        checks++; if (busy !== 64'd0) begin errors++; $display("FAIL fl_busy: got %0h expected 0", busy); end
        checks++; if (fu_valid !== 1'b0) begin errors++; $display("FAIL fl_post_valid: got %b expected 0", fu_valid); end
        checks++; if (stall_cnt !== 32'(stall_exp)) begin errors++; $display("FAIL fl_stall_cnt: got %0d expected %0d", stall_cnt, stall_exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = fire_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(6'd0, 1'b0, 6'd0, 1'b0, 6'(i + 1), 1'b1, pl(20 + i));
            @(negedge clk);
            checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b expected 1", i, instr_ack); end
            if (i > 0) begin
                checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL b2b_fire%0d: got %b expected 1", i, fu_valid); end
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (fu_valid !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b expected 1", fu_valid); end
        tick();
        @(negedge clk);
        checks++; if (fire_cnt - f0 !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", fire_cnt - f0); end
        checks++; if (stall_cnt !== 32'(stall_exp)) begin errors++; $display("FAIL b2b_stall_cnt: got %0d expected %0d", stall_cnt, stall_exp); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_x0();
        test_backpressure();
        test_waw();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
